// File: rtl/eerrl_pkg.sv
// Shared EER-RL node types: updater FSM states, word width, packet types, neighbor record.
package eerrl_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH = 16;

  // Packet-type codes agreed with the packet-field extractor
  localparam int unsigned PKT_TYPE_W = 3;
  localparam logic [PKT_TYPE_W-1:0] PKT_HELLO    = 3'd1;
  localparam logic [PKT_TYPE_W-1:0] PKT_CH_ADV   = 3'd2;
  localparam logic [PKT_TYPE_W-1:0] PKT_JOIN_REQ = 3'd3;
  localparam logic [PKT_TYPE_W-1:0] PKT_DATA     = 3'd4;
  localparam logic [PKT_TYPE_W-1:0] PKT_ACK      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN_N   = 3'd1,
    S_WRITE_N  = 3'd2,
    S_SCAN_CH  = 3'd3,
    S_WRITE_CH = 3'd4,
    S_BEST     = 3'd5,
    S_DONE     = 3'd6
  } ntu_state_e;

  typedef struct packed {
    logic [DEFAULT_WORD_WIDTH-1:0] id;
    logic [DEFAULT_WORD_WIDTH-1:0] cluster;
    logic [DEFAULT_WORD_WIDTH-1:0] energy;
    logic [DEFAULT_WORD_WIDTH-1:0] q;
  } nbr_rec_t;

endpackage

// File: rtl/neighbor_table_update_if.sv
// Packet-field, read-port and status bundle between the updater and its neighbors.
interface neighbor_table_update_if
  import eerrl_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = DEFAULT_WORD_WIDTH,
  parameter int unsigned MAX_NEIGHBORS = 32,
  parameter int unsigned MAX_KNOWNCH   = 8
);
  localparam int unsigned IDXW  = $clog2(MAX_NEIGHBORS);
  localparam int unsigned CIDXW = $clog2(MAX_KNOWNCH);

  logic                  en;
  logic [WORD_WIDTH-1:0] fSourceID;
  logic [WORD_WIDTH-1:0] fClusterID;
  logic [WORD_WIDTH-1:0] fEnergyLeft;
  logic [WORD_WIDTH-1:0] fQValue;
  logic [IDXW-1:0]       rd_idx;
  logic [WORD_WIDTH-1:0] rdSourceID;
  logic [WORD_WIDTH-1:0] rdClusterID;
  logic [WORD_WIDTH-1:0] rdEnergy;
  logic [WORD_WIDTH-1:0] rdQValue;
  logic [CIDXW-1:0]      rdch_idx;
  logic [WORD_WIDTH-1:0] rdKnownCH;
  logic [WORD_WIDTH-1:0] neighborCount;
  logic [WORD_WIDTH-1:0] knownCHCount;
  logic [IDXW-1:0]       bestIdx;
  logic [WORD_WIDTH-1:0] bestQValue;
  logic                  busy;
  logic                  done;
  logic                  nbr_drop;
  logic                  ch_drop;

  modport master (
    output en, fSourceID, fClusterID, fEnergyLeft, fQValue, rd_idx, rdch_idx,
    input  rdSourceID, rdClusterID, rdEnergy, rdQValue, rdKnownCH,
    input  neighborCount, knownCHCount, bestIdx, bestQValue,
    input  busy, done, nbr_drop, ch_drop
  );

  modport slave (
    input  en, fSourceID, fClusterID, fEnergyLeft, fQValue, rd_idx, rdch_idx,
    output rdSourceID, rdClusterID, rdEnergy, rdQValue, rdKnownCH,
    output neighborCount, knownCHCount, bestIdx, bestQValue,
    output busy, done, nbr_drop, ch_drop
  );

endinterface

// File: rtl/id_list_scan.sv
// Sequential ID matcher: walks one list entry per cycle from index 0 until a hit or the end.
module id_list_scan #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned IDX_W      = 6
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start_i,
  input  logic                  scan_i,
  input  logic [WORD_WIDTH-1:0] key_i,
  input  logic [WORD_WIDTH-1:0] count_i,
  input  logic [WORD_WIDTH-1:0] entry_id_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  match_c_o,
  output logic                  done_c_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             at_end_c;

  // Index equal to count means every valid entry was examined without a hit
  assign at_end_c  = (WORD_WIDTH'(idx_q) == count_i);
  assign match_c_o = !at_end_c && (entry_id_i == key_i);
  assign done_c_o  = at_end_c || match_c_o;
  assign idx_o     = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (start_i) begin
      idx_d = '0;
    end else if (scan_i && !done_c_o) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/neighbor_table_update.sv
// Neighbor-table and known-CH updater for the EER-RL node.
// Define QTABLE_BEST_HOP_EN to enable the max-Q best-next-hop rescan.
module neighbor_table_update
  import eerrl_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = DEFAULT_WORD_WIDTH,
  parameter int unsigned MAX_NEIGHBORS = 32,
  parameter int unsigned MAX_KNOWNCH   = 8
) (
  input  logic                    clk,
  input  logic                    nrst,
  neighbor_table_update_if.slave  bus
);

  localparam int unsigned IDXW  = $clog2(MAX_NEIGHBORS);
  localparam int unsigned CIDXW = $clog2(MAX_KNOWNCH);
  localparam int unsigned NSW   = IDXW + 1;
  localparam int unsigned CSW   = CIDXW + 1;

  // Record fields are sized by the package word width
  nbr_rec_t              nbr_q [MAX_NEIGHBORS];
  logic [WORD_WIDTH-1:0] ch_q  [MAX_KNOWNCH];

  ntu_state_e            state_q, state_d;
  logic [WORD_WIDTH-1:0] nbr_cnt_q, nbr_cnt_d;
  logic [WORD_WIDTH-1:0] ch_cnt_q, ch_cnt_d;
  logic                  nbr_flag_q, nbr_flag_d;
  logic                  ch_flag_q, ch_flag_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  nbr_drop_q, nbr_drop_d;
  logic                  ch_drop_q, ch_drop_d;

  logic                  start_c;
  logic                  nbr_we_c, nbr_app_c, ch_we_c;
  logic [NSW-1:0]        n_idx;
  logic [CSW-1:0]        k_idx;
  logic                  n_match, n_done, k_match, k_done;
  logic [WORD_WIDTH-1:0] nbr_id_c, ch_id_c;
  logic                  best_last_c;
  nbr_rec_t              rd_rec_c;

  assign nbr_id_c = WORD_WIDTH'(nbr_q[n_idx[IDXW-1:0]].id);
  assign ch_id_c  = ch_q[k_idx[CIDXW-1:0]];

  id_list_scan #(.WORD_WIDTH(WORD_WIDTH), .IDX_W(NSW)) u_nbr_scan (
    .clk        (clk),
    .nrst       (nrst),
    .start_i    (start_c),
    .scan_i     (state_q == S_SCAN_N),
    .key_i      (bus.fSourceID),
    .count_i    (nbr_cnt_q),
    .entry_id_i (nbr_id_c),
    .idx_o      (n_idx),
    .match_c_o  (n_match),
    .done_c_o   (n_done)
  );

  id_list_scan #(.WORD_WIDTH(WORD_WIDTH), .IDX_W(CSW)) u_ch_scan (
    .clk        (clk),
    .nrst       (nrst),
    .start_i    (start_c),
    .scan_i     (state_q == S_SCAN_CH),
    .key_i      (bus.fClusterID),
    .count_i    (ch_cnt_q),
    .entry_id_i (ch_id_c),
    .idx_o      (k_idx),
    .match_c_o  (k_match),
    .done_c_o   (k_done)
  );

`ifdef QTABLE_BEST_HOP_EN
  logic [NSW-1:0]        b_q, b_d;
  logic [WORD_WIDTH-1:0] run_q, run_d;
  logic [IDXW-1:0]       run_idx_q, run_idx_d;
  logic [IDXW-1:0]       best_idx_q, best_idx_d;
  logic [WORD_WIDTH-1:0] best_qv_q, best_qv_d;
  logic [WORD_WIDTH-1:0] cand_c;

  assign cand_c      = WORD_WIDTH'(nbr_q[b_q[IDXW-1:0]].q);
  assign best_last_c = (state_q == S_BEST) && (WORD_WIDTH'(b_q) == nbr_cnt_q);

  // Full rescan each update; strict compare keeps the lowest index on ties
  always_comb begin
    b_d        = b_q;
    run_d      = run_q;
    run_idx_d  = run_idx_q;
    best_idx_d = best_idx_q;
    best_qv_d  = best_qv_q;
    if (state_q != S_BEST) begin
      b_d       = '0;
      run_d     = '0;
      run_idx_d = '0;
    end else if (best_last_c) begin
      best_idx_d = run_idx_q;
      best_qv_d  = run_q;
    end else begin
      b_d = b_q + NSW'(1);
      if (cand_c > run_q) begin
        run_d     = cand_c;
        run_idx_d = IDXW'(b_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      b_q        <= '0;
      run_q      <= '0;
      run_idx_q  <= '0;
      best_idx_q <= '0;
      best_qv_q  <= '0;
    end else begin
      b_q        <= b_d;
      run_q      <= run_d;
      run_idx_q  <= run_idx_d;
      best_idx_q <= best_idx_d;
      best_qv_q  <= best_qv_d;
    end
  end

  assign bus.bestIdx    = best_idx_q;
  assign bus.bestQValue = best_qv_q;
`else
  assign best_last_c    = (state_q == S_BEST);
  assign bus.bestIdx    = '0;
  assign bus.bestQValue = '0;
`endif

  // Next-state, counters, drop flags and write strobes
  always_comb begin
    state_d    = state_q;
    nbr_cnt_d  = nbr_cnt_q;
    ch_cnt_d   = ch_cnt_q;
    nbr_flag_d = nbr_flag_q;
    ch_flag_d  = ch_flag_q;
    start_c    = 1'b0;
    nbr_we_c   = 1'b0;
    nbr_app_c  = 1'b0;
    ch_we_c    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    nbr_drop_d = 1'b0;
    ch_drop_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          start_c    = 1'b1;
          nbr_flag_d = 1'b0;
          ch_flag_d  = 1'b0;
          state_d    = S_SCAN_N;
        end
      end
      S_SCAN_N: begin
        if (n_done) state_d = S_WRITE_N;
      end
      S_WRITE_N: begin
        if (n_match) begin
          nbr_we_c = 1'b1;
        end else if (nbr_cnt_q < WORD_WIDTH'(MAX_NEIGHBORS)) begin
          nbr_we_c  = 1'b1;
          nbr_app_c = 1'b1;
          nbr_cnt_d = nbr_cnt_q + WORD_WIDTH'(1);
        end else begin
          nbr_flag_d = 1'b1;
        end
        // Cluster ID 0 marks an unaffiliated sender: no CH to register
        state_d = (bus.fClusterID == '0) ? S_BEST : S_SCAN_CH;
      end
      S_SCAN_CH: begin
        if (k_done) state_d = k_match ? S_BEST : S_WRITE_CH;
      end
      S_WRITE_CH: begin
        if (ch_cnt_q < WORD_WIDTH'(MAX_KNOWNCH)) begin
          ch_we_c  = 1'b1;
          ch_cnt_d = ch_cnt_q + WORD_WIDTH'(1);
        end else begin
          ch_flag_d = 1'b1;
        end
        state_d = S_BEST;
      end
      S_BEST: begin
        if (best_last_c) state_d = S_DONE;
      end
      S_DONE: begin
        nbr_flag_d = 1'b0;
        ch_flag_d  = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    nbr_drop_d = (state_d == S_DONE) && nbr_flag_q;
    ch_drop_d  = (state_d == S_DONE) && ch_flag_q;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      nbr_cnt_q  <= '0;
      ch_cnt_q   <= '0;
      nbr_flag_q <= 1'b0;
      ch_flag_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nbr_drop_q <= 1'b0;
      ch_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      nbr_cnt_q  <= nbr_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      nbr_flag_q <= nbr_flag_d;
      ch_flag_q  <= ch_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nbr_drop_q <= nbr_drop_d;
      ch_drop_q  <= ch_drop_d;
    end
  end

  // Table storage is masked by the counts, so it needs no reset
  always_ff @(posedge clk) begin
    if (nbr_we_c) begin
      nbr_q[n_idx[IDXW-1:0]].cluster <= DEFAULT_WORD_WIDTH'(bus.fClusterID);
      nbr_q[n_idx[IDXW-1:0]].energy  <= DEFAULT_WORD_WIDTH'(bus.fEnergyLeft);
      nbr_q[n_idx[IDXW-1:0]].q       <= DEFAULT_WORD_WIDTH'(bus.fQValue);
      if (nbr_app_c) begin
        nbr_q[n_idx[IDXW-1:0]].id <= DEFAULT_WORD_WIDTH'(bus.fSourceID);
      end
    end
    if (ch_we_c) begin
      ch_q[ch_cnt_q[CIDXW-1:0]] <= bus.fClusterID;
    end
  end

  assign rd_rec_c = nbr_q[bus.rd_idx];

  assign bus.rdSourceID  = (WORD_WIDTH'(bus.rd_idx) < nbr_cnt_q) ? WORD_WIDTH'(rd_rec_c.id)      : '0;
  assign bus.rdClusterID = (WORD_WIDTH'(bus.rd_idx) < nbr_cnt_q) ? WORD_WIDTH'(rd_rec_c.cluster) : '0;
  assign bus.rdEnergy    = (WORD_WIDTH'(bus.rd_idx) < nbr_cnt_q) ? WORD_WIDTH'(rd_rec_c.energy)  : '0;
  assign bus.rdQValue    = (WORD_WIDTH'(bus.rd_idx) < nbr_cnt_q) ? WORD_WIDTH'(rd_rec_c.q)       : '0;
  assign bus.rdKnownCH   = (WORD_WIDTH'(bus.rdch_idx) < ch_cnt_q) ? ch_q[bus.rdch_idx] : '0;

  assign bus.neighborCount = nbr_cnt_q;
  assign bus.knownCHCount  = ch_cnt_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.nbr_drop      = nbr_drop_q;
  assign bus.ch_drop       = ch_drop_q;

endmodule
